// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - six-digit multiplexed 7-segment scan sequencer
// Double-buffered display value; new data only takes effect on a frame boundary.
module seg_scan_ctrl #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned BLANK    = 1
) (
  input  logic        Clk,
  input  logic        Clr_n,
  input  logic        En,
  input  logic        Load,
  input  logic [23:0] Value,
  input  logic [5:0]  Blank_mask,
  output logic [3:0]  Nibble,
  output logic [5:0]  Dig_en,
  output logic [2:0]  Digit_idx,
  output logic        Ack,
  output logic        Frame_start
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [15:0] SHOW_LAST = 16'(PRESCALE - 1);
  localparam logic [15:0] GAP_LAST  = (BLANK == 0) ? 16'd0 : 16'(BLANK - 1);
  localparam bit          HAS_GAP   = (BLANK != 0);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  idx_q;
  logic        stop_q;
  logic [23:0] active_val_q;
  logic [5:0]  active_mask_q;
  logic [23:0] shadow_val_q;
  logic [5:0]  shadow_mask_q;
  logic        pending_q;
  logic [3:0]  nibble_q;
  logic [5:0]  dig_en_q;
  logic        ack_q;
  logic        frame_start_q;

  logic        show_done;
  logic        gap_done;
  logic        digit_done;
  logic        stopping;
  logic        start_frame;
  logic        enter_show;
  logic        enter_idle;
  logic [23:0] active_val_d;
  logic [5:0]  active_mask_d;
  logic [2:0]  tgt_idx;
  logic [23:0] tgt_val;
  logic [5:0]  tgt_mask;
  logic [3:0]  tgt_nib;
  logic [5:0]  tgt_onehot;
  logic [5:0]  tgt_en;

  always_comb begin
    show_done   = (state_q == SHOW) && (cnt_q == SHOW_LAST);
    gap_done    = (state_q == GAP) && (cnt_q == GAP_LAST);
    digit_done  = HAS_GAP ? gap_done : show_done;
    stopping    = stop_q || !En;
    start_frame = ((state_q == IDLE) && En) ||
                  (digit_done && !stopping && (idx_q == 3'd5));
    enter_show  = ((state_q == IDLE) && En) || (digit_done && !stopping);
    enter_idle  = digit_done && stopping;

    // A Load landing on the boundary edge bypasses the shadow entirely.
    if (Load) begin
      active_val_d  = Value;
      active_mask_d = Blank_mask;
    end else if (pending_q) begin
      active_val_d  = shadow_val_q;
      active_mask_d = shadow_mask_q;
    end else begin
      active_val_d  = active_val_q;
      active_mask_d = active_mask_q;
    end

    tgt_idx  = start_frame ? 3'd0 : idx_q + 3'd1;
    tgt_val  = start_frame ? active_val_d : active_val_q;
    tgt_mask = start_frame ? active_mask_d : active_mask_q;

    tgt_nib    = 4'd0;
    tgt_onehot = 6'd0;
    case (tgt_idx)
      3'd0: begin tgt_nib = tgt_val[3:0];   tgt_onehot = 6'b000001; end
      3'd1: begin tgt_nib = tgt_val[7:4];   tgt_onehot = 6'b000010; end
      3'd2: begin tgt_nib = tgt_val[11:8];  tgt_onehot = 6'b000100; end
      3'd3: begin tgt_nib = tgt_val[15:12]; tgt_onehot = 6'b001000; end
      3'd4: begin tgt_nib = tgt_val[19:16]; tgt_onehot = 6'b010000; end
      3'd5: begin tgt_nib = tgt_val[23:20]; tgt_onehot = 6'b100000; end
      default: ;
    endcase
    tgt_en = tgt_onehot & ~tgt_mask;
  end

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      idx_q         <= 3'd0;
      stop_q        <= 1'b0;
      active_val_q  <= 24'd0;
      active_mask_q <= 6'd0;
      shadow_val_q  <= 24'd0;
      shadow_mask_q <= 6'd0;
      pending_q     <= 1'b0;
      nibble_q      <= 4'd0;
      dig_en_q      <= 6'd0;
      ack_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      ack_q         <= 1'b0;
      frame_start_q <= 1'b0;

      if (start_frame) begin
        active_val_q  <= active_val_d;
        active_mask_q <= active_mask_d;
        pending_q     <= 1'b0;
        ack_q         <= Load || pending_q;
        frame_start_q <= 1'b1;
      end else if (Load) begin
        shadow_val_q  <= Value;
        shadow_mask_q <= Blank_mask;
        pending_q     <= 1'b1;
      end

      if (enter_show) begin
        state_q  <= SHOW;
        cnt_q    <= 16'd0;
        idx_q    <= tgt_idx;
        nibble_q <= tgt_nib;
        dig_en_q <= tgt_en;
        stop_q   <= 1'b0;
      end else if (enter_idle) begin
        state_q  <= IDLE;
        cnt_q    <= 16'd0;
        idx_q    <= 3'd0;
        dig_en_q <= 6'd0;
        stop_q   <= 1'b0;
      end else begin
        // A disable mid-digit is remembered so the digit still runs to completion.
        case (state_q)
          IDLE: begin
            dig_en_q <= 6'd0;
            stop_q   <= 1'b0;
          end
          SHOW: begin
            stop_q <= stop_q || !En;
            if (show_done) begin
              state_q  <= GAP;
              cnt_q    <= 16'd0;
              dig_en_q <= 6'd0;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
          GAP: begin
            stop_q <= stop_q || !En;
            cnt_q  <= cnt_q + 16'd1;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Nibble      = nibble_q;
  assign Dig_en      = dig_en_q;
  assign Digit_idx   = idx_q;
  assign Ack         = ack_q;
  assign Frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed bench for seg_scan_ctrl (4/1 and 1/0 configurations)
module tb_seg_scan_ctrl;

  logic        Clk = 1'b0;
  logic        clr_a, en_a, clr_b, en_b, Load;
  logic [23:0] Value;
  logic [5:0]  Blank_mask;

  logic [3:0]  a_nib, b_nib;
  logic [5:0]  a_dig, b_dig;
  logic [2:0]  a_idx, b_idx;
  logic        a_ack, b_ack, a_fs, b_fs;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  seg_scan_ctrl #(.PRESCALE(4), .BLANK(1)) u_dut (
    .Clk(Clk), .Clr_n(clr_a), .En(en_a), .Load(Load), .Value(Value),
    .Blank_mask(Blank_mask), .Nibble(a_nib), .Dig_en(a_dig),
    .Digit_idx(a_idx), .Ack(a_ack), .Frame_start(a_fs)
  );

  seg_scan_ctrl #(.PRESCALE(1), .BLANK(0)) u_dut_fast (
    .Clk(Clk), .Clr_n(clr_b), .En(en_b), .Load(Load), .Value(Value),
    .Blank_mask(Blank_mask), .Nibble(b_nib), .Dig_en(b_dig),
    .Digit_idx(b_idx), .Ack(b_ack), .Frame_start(b_fs)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One 30-cycle frame of the 4/1 instance, starting at its first SHOW cycle.
  task automatic frame(input logic [23:0] v, input logic [5:0] m, input bit ack0,
                       input int ld_k1, input logic [23:0] ld_v1, input logic [5:0] ld_m1,
                       input int ld_k2, input logic [23:0] ld_v2, input int stop_k);
    for (int k = 0; k < 30; k++) begin
      int d;
      int c;
      logic [23:0] sh;
      d  = k / 5;
      c  = k % 5;
      sh = v >> (4 * d);
      chk("dig_en", 32'(a_dig), (c < 4 && !m[d]) ? (32'd1 << d) : 32'd0);
      chk("nibble", 32'(a_nib), 32'(sh[3:0]));
      chk("digit_idx", 32'(a_idx), 32'(d));
      chk("frame_start", 32'(a_fs), (k == 0) ? 32'd1 : 32'd0);
      chk("ack", 32'(a_ack), (ack0 && k == 0) ? 32'd1 : 32'd0);
      if (k == ld_k1) begin Load = 1'b1; Value = ld_v1; Blank_mask = ld_m1; end
      if (k == ld_k2) begin Load = 1'b1; Value = ld_v2; Blank_mask = ld_m1; end
      if (k == stop_k) en_a = 1'b0;
      tick();
      Load = 1'b0;
      if (stop_k >= 0 && k == (stop_k / 5) * 5 + 4) break;
    end
  endtask

  initial begin
    clr_a = 1'b0; en_a = 1'b0; clr_b = 1'b0; en_b = 1'b0;
    Load = 1'b0; Value = 24'd0; Blank_mask = 6'd0;
    tick();
    tick();
    chk("rst_nibble", 32'(a_nib), 32'd0);
    chk("rst_dig_en", 32'(a_dig), 32'd0);
    chk("rst_idx", 32'(a_idx), 32'd0);
    chk("rst_ack", 32'(a_ack), 32'd0);
    chk("rst_fs", 32'(a_fs), 32'd0);

    clr_a = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_dig_en", 32'(a_dig), 32'd0);
      chk("idle_fs", 32'(a_fs), 32'd0);
    end

    Load = 1'b1; Value = 24'h5A3C21; Blank_mask = 6'd0;
    tick();
    Load = 1'b0;
    chk("idle_load_ack", 32'(a_ack), 32'd0);
    chk("idle_load_dig", 32'(a_dig), 32'd0);

    en_a = 1'b1;
    tick();
    frame(24'h5A3C21, 6'd0, 1'b1, -1, 24'd0, 6'd0, -1, 24'd0, -1);
    frame(24'h5A3C21, 6'd0, 1'b0, 10, 24'h111111, 6'd0, 20, 24'h222222, -1);
    frame(24'h222222, 6'd0, 1'b1, -1, 24'd0, 6'd0, -1, 24'd0, -1);
    frame(24'h222222, 6'd0, 1'b0, 29, 24'hFFFFFF, 6'd0, -1, 24'd0, -1);
    frame(24'hFFFFFF, 6'd0, 1'b1, -1, 24'd0, 6'd0, -1, 24'd0, -1);
    frame(24'hFFFFFF, 6'd0, 1'b0, 7, 24'h654321, 6'b100001, -1, 24'd0, -1);
    frame(24'h654321, 6'b100001, 1'b1, -1, 24'd0, 6'd0, -1, 24'd0, 15);

    for (int i = 0; i < 5; i++) begin
      chk("stop_dig_en", 32'(a_dig), 32'd0);
      chk("stop_fs", 32'(a_fs), 32'd0);
      tick();
    end

    en_a = 1'b1;
    tick();
    frame(24'h654321, 6'b100001, 1'b0, -1, 24'd0, 6'd0, -1, 24'd0, -1);

    Load = 1'b1; Value = 24'hABCDEF; Blank_mask = 6'd0;
    tick();
    Load = 1'b0;
    tick();
    #2;
    clr_a = 1'b0;
    en_a  = 1'b0;
    #1;
    chk("async_nibble", 32'(a_nib), 32'd0);
    chk("async_dig_en", 32'(a_dig), 32'd0);
    chk("async_idx", 32'(a_idx), 32'd0);
    chk("async_ack", 32'(a_ack), 32'd0);
    chk("async_fs", 32'(a_fs), 32'd0);
    tick();
    clr_a = 1'b1;
    tick();
    tick();
    chk("post_rst_dig_en", 32'(a_dig), 32'd0);
    en_a = 1'b1;
    tick();
    chk("post_rst_fs", 32'(a_fs), 32'd1);
    chk("post_rst_ack", 32'(a_ack), 32'd0);
    chk("post_rst_nibble", 32'(a_nib), 32'd0);
    chk("post_rst_dig_en1", 32'(a_dig), 32'd1);
    chk("post_rst_idx", 32'(a_idx), 32'd0);
    en_a = 1'b0;

    clr_b = 1'b1;
    tick();
    en_b = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("fast_dig_en", 32'(b_dig), 32'd1 << (i % 6));
      chk("fast_idx", 32'(b_idx), 32'(i % 6));
      chk("fast_fs", 32'(b_fs), (i % 6 == 0) ? 32'd1 : 32'd0);
      chk("fast_ack", 32'(b_ack), 32'd0);
      chk("fast_nibble", 32'(b_nib), 32'd0);
      if (i < 15) tick();
    end
    #2;
    clr_b = 1'b0;
    #1;
    chk("fast_rst_dig_en", 32'(b_dig), 32'd0);
    chk("fast_rst_idx", 32'(b_idx), 32'd0);
    chk("fast_rst_fs", 32'(b_fs), 32'd0);
    tick();
    clr_b = 1'b1;
    tick();
    chk("fast_restart_dig_en", 32'(b_dig), 32'd1);
    chk("fast_restart_fs", 32'(b_fs), 32'd1);
    chk("fast_restart_idx", 32'(b_idx), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
